dcache_rd_ctrl: RTL and testbench

- Read controller for one load port (LSU or PTW) of the write-through L1 data cache.
- Accepts core read requests and arbitrates for the shared tag/data array read port.
- Checks the tag-hit result; on a miss or when the cache is disabled, issues a miss request to the miss unit and waits for the refill return.
- Handles kill, replay and refill-collision cases.

---
 rtl/dcache_rd_ctrl_if.sv | 62 ++++++
 rtl/dcache_rd_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_dcache_rd_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_rd_ctrl_if.sv
// Bundle of the core, miss-unit and tag/data-array signals for one dcache read port.
// Signal names keep the _i/_o direction of the controller side.
interface dcache_rd_ctrl_if #(
    parameter int PLEN  = 56,
    parameter int TAG_W = 44,
    parameter int IDX_W = 8,
    parameter int OFF_W = 4,
    parameter int WAYS  = 8
);
    logic                   cache_en_i;
    logic                   stall_i;
    logic                   busy_o;
    logic                   req_i;
    logic [IDX_W+OFF_W-1:0] addr_index_i;
    logic [TAG_W-1:0]       addr_tag_i;
    logic                   tag_valid_i;
    logic                   kill_i;
    logic [1:0]             size_i;
    logic                   gnt_o;
    logic                   rvalid_o;
    logic [63:0]            rdata_o;
    logic                   miss_req_o;
    logic                   miss_ack_i;
    logic                   miss_nc_o;
    logic                   miss_we_o;
    logic [63:0]            miss_wdata_o;
    logic [PLEN-1:0]        miss_paddr_o;
    logic [WAYS-1:0]        miss_vld_bits_o;
    logic [2:0]             miss_size_o;
    logic [3:0]             miss_id_o;
    logic                   miss_replay_i;
    logic                   miss_rtrn_vld_i;
    logic [63:0]            miss_rtrn_data_i;
    logic                   wr_cl_vld_i;
    logic                   rd_req_o;
    logic                   rd_ack_i;
    logic [IDX_W-1:0]       rd_idx_o;
    logic [OFF_W-1:0]       rd_off_o;
    logic [TAG_W-1:0]       rd_tag_o;
    logic                   rd_tag_only_o;
    logic [63:0]            rd_data_i;
    logic [WAYS-1:0]        rd_vld_bits_i;
    logic [WAYS-1:0]        rd_hit_oh_i;

    modport slave (
        input  cache_en_i, stall_i, req_i, addr_index_i, addr_tag_i, tag_valid_i, kill_i, size_i,
               miss_ack_i, miss_replay_i, miss_rtrn_vld_i, miss_rtrn_data_i, wr_cl_vld_i,
               rd_ack_i, rd_data_i, rd_vld_bits_i, rd_hit_oh_i,
        output busy_o, gnt_o, rvalid_o, rdata_o, miss_req_o, miss_nc_o, miss_we_o, miss_wdata_o,
               miss_paddr_o, miss_vld_bits_o, miss_size_o, miss_id_o,
               rd_req_o, rd_idx_o, rd_off_o, rd_tag_o, rd_tag_only_o
    );

    modport master (
        output cache_en_i, stall_i, req_i, addr_index_i, addr_tag_i, tag_valid_i, kill_i, size_i,
               miss_ack_i, miss_replay_i, miss_rtrn_vld_i, miss_rtrn_data_i, wr_cl_vld_i,
               rd_ack_i, rd_data_i, rd_vld_bits_i, rd_hit_oh_i,
        input  busy_o, gnt_o, rvalid_o, rdata_o, miss_req_o, miss_nc_o, miss_we_o, miss_wdata_o,
               miss_paddr_o, miss_vld_bits_o, miss_size_o, miss_id_o,
               rd_req_o, rd_idx_o, rd_off_o, rd_tag_o, rd_tag_only_o
    );
endinterface

// File: rtl/dcache_rd_ctrl.sv
// Load-port read controller for the write-through L1 dcache: lookup, miss, kill and replay handling.
// Define DCACHE_RD_CTRL_PIPELINE_EN to allow back-to-back hits (grant a new request on a hit cycle).
module dcache_rd_ctrl #(
    parameter int RD_TX_ID = 1,
    parameter int PLEN     = 56,
    parameter int TAG_W    = 44,
    parameter int IDX_W    = 8,
    parameter int OFF_W    = 4,
    parameter int WAYS     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dcache_rd_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, READ, MISS_REQ, MISS_WAIT, KILL_MISS, REPLAY_REQ, REPLAY_READ
    } state_e;

    state_e            state_r, state_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [OFF_W-1:0]  off_r;
    logic [TAG_W-1:0]  tag_r;
    logic [1:0]        size_r;
    logic [WAYS-1:0]   vld_r;
    logic              busy_r, miss_req_r;

    logic              new_req_s, look_s, hit_s;
    logic              gnt_s, rvalid_s, rd_req_s, cap_req_s, cap_tag_s, cap_vld_s;
    logic [63:0]       rdata_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [OFF_W-1:0]  rd_off_s;
    logic [TAG_W-1:0]  rd_tag_s;

    assign new_req_s = bus.req_i && !bus.stall_i;
    // A replayed lookup already owns a valid tag; a first lookup waits for it.
    assign look_s    = (state_r == REPLAY_READ) || ((state_r == READ) && bus.tag_valid_i);
    assign hit_s     = (|bus.rd_hit_oh_i) && bus.cache_en_i;

    // Next-state decode and the handshake outputs that must respond within the cycle.
    always_comb begin
        state_nxt_s = state_r;
        gnt_s       = 1'b0;
        rvalid_s    = 1'b0;
        rdata_s     = 64'h0;
        rd_req_s    = 1'b0;
        rd_idx_s    = idx_r;
        rd_off_s    = off_r;
        rd_tag_s    = tag_r;
        cap_req_s   = 1'b0;
        cap_tag_s   = 1'b0;
        cap_vld_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (new_req_s) begin
                    rd_req_s = 1'b1;
                    rd_idx_s = bus.addr_index_i[IDX_W+OFF_W-1:OFF_W];
                    rd_off_s = bus.addr_index_i[OFF_W-1:0];
                    if (bus.rd_ack_i) begin
                        gnt_s       = 1'b1;
                        cap_req_s   = 1'b1;
                        state_nxt_s = READ;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ, REPLAY_READ: begin
                if (state_r == READ) begin
                    rd_tag_s  = bus.addr_tag_i;
                    cap_tag_s = bus.tag_valid_i;
                end else begin
                    rd_tag_s  = tag_r;
                end
                if (!look_s) begin
                    state_nxt_s = state_r;
                end else if (bus.kill_i) begin
                    state_nxt_s = IDLE;
                end else if (bus.wr_cl_vld_i) begin
                    state_nxt_s = REPLAY_REQ;
                end else if (hit_s) begin
                    rvalid_s    = 1'b1;
                    rdata_s     = bus.rd_data_i;
                    state_nxt_s = IDLE;
`ifdef DCACHE_RD_CTRL_PIPELINE_EN
                    if (new_req_s) begin
                        rd_req_s = 1'b1;
                        rd_idx_s = bus.addr_index_i[IDX_W+OFF_W-1:OFF_W];
                        rd_off_s = bus.addr_index_i[OFF_W-1:0];
                        if (bus.rd_ack_i) begin
                            gnt_s       = 1'b1;
                            cap_req_s   = 1'b1;
                            state_nxt_s = READ;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
`else
                    state_nxt_s = IDLE;
`endif
                end else begin
                    cap_vld_s   = 1'b1;
                    state_nxt_s = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (bus.kill_i && !bus.miss_ack_i) begin
                    state_nxt_s = IDLE;
                end else if (bus.miss_replay_i) begin
                    state_nxt_s = REPLAY_REQ;
                end else if (bus.miss_ack_i) begin
                    state_nxt_s = bus.kill_i ? KILL_MISS : MISS_WAIT;
                end else begin
                    state_nxt_s = MISS_REQ;
                end
            end
            MISS_WAIT: begin
                if (bus.miss_rtrn_vld_i) begin
                    rvalid_s    = 1'b1;
                    rdata_s     = bus.miss_rtrn_data_i;
                    state_nxt_s = IDLE;
                end else if (bus.kill_i) begin
                    state_nxt_s = KILL_MISS;
                end else begin
                    state_nxt_s = MISS_WAIT;
                end
            end
            // The refill is already in flight, so it must be drained before reuse.
            KILL_MISS: begin
                if (bus.miss_rtrn_vld_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = KILL_MISS;
                end
            end
            REPLAY_REQ: begin
                rd_req_s = 1'b1;
                if (bus.kill_i) begin
                    state_nxt_s = IDLE;
                end else if (bus.rd_ack_i) begin
                    state_nxt_s = REPLAY_READ;
                end else begin
                    state_nxt_s = REPLAY_REQ;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register, registered status flags and captured request fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            miss_req_r <= 1'b0;
            idx_r      <= '0;
            off_r      <= '0;
            tag_r      <= '0;
            size_r     <= 2'b00;
            vld_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            miss_req_r <= (state_nxt_s == MISS_REQ);
            if (cap_req_s) begin
                idx_r  <= bus.addr_index_i[IDX_W+OFF_W-1:OFF_W];
                off_r  <= bus.addr_index_i[OFF_W-1:0];
                size_r <= bus.size_i;
            end
            if (cap_tag_s) begin
                tag_r <= bus.addr_tag_i;
            end
            if (cap_vld_s) begin
                vld_r <= bus.rd_vld_bits_i;
            end
        end
    end

    assign bus.busy_o          = busy_r;
    assign bus.gnt_o           = gnt_s;
    assign bus.rvalid_o        = rvalid_s;
    assign bus.rdata_o         = rdata_s;
    assign bus.miss_req_o      = miss_req_r;
    assign bus.miss_nc_o       = miss_req_r && !bus.cache_en_i;
    assign bus.miss_we_o       = 1'b0;
    assign bus.miss_wdata_o    = 64'h0;
    assign bus.miss_paddr_o    = PLEN'({tag_r, idx_r, off_r});
    assign bus.miss_vld_bits_o = vld_r;
    assign bus.miss_size_o     = {1'b0, size_r};
    assign bus.miss_id_o       = 4'(RD_TX_ID);
    assign bus.rd_req_o        = rd_req_s;
    assign bus.rd_idx_o        = rd_idx_s;
    assign bus.rd_off_o        = rd_off_s;
    assign bus.rd_tag_o        = rd_tag_s;
    assign bus.rd_tag_only_o   = 1'b0;
endmodule

// File: tb/tb_dcache_rd_ctrl.sv
// Bench for dcache_rd_ctrl: directed per-cycle vector table, then randomized transactions
// checked against per-transaction expectations (data returned, kills, grant/rvalid counts).
module tb_dcache_rd_ctrl;
    localparam int K_HIT = 0, K_MISS = 1, K_COLL = 2, K_RPLY = 3, K_KILL = 4;

    // f = {req, stall, ack, tag_valid, kill, wr_cl, cache_en, miss_ack, replay, rtrn_vld}
    // e = {gnt, rvalid, rd_req, miss_req, busy, nc}
    typedef struct packed {
        logic [9:0]  f;
        logic [7:0]  hit;
        logic [7:0]  vld;
        logic [63:0] dat;
        logic [5:0]  e;
        logic [7:0]  evld;
    } vec_t;

    logic clk, rst_n;
    int   pass_cnt = 0, total_cnt = 0;
    int   rv_cnt = 0, gnt_cnt = 0;
    vec_t vq[$];

    dcache_rd_ctrl_if bus ();
    dcache_rd_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (bus.rvalid_o === 1'b1) rv_cnt++;
            if (bus.gnt_o === 1'b1) gnt_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_def();
        bus.req_i = 1'b0; bus.stall_i = 1'b0; bus.rd_ack_i = 1'b0; bus.tag_valid_i = 1'b0;
        bus.kill_i = 1'b0; bus.wr_cl_vld_i = 1'b0; bus.cache_en_i = 1'b1; bus.miss_ack_i = 1'b0;
        bus.miss_replay_i = 1'b0; bus.miss_rtrn_vld_i = 1'b0; bus.rd_hit_oh_i = 8'h00;
    endtask

    task automatic add(input logic [9:0] f, input logic [7:0] hit, input logic [7:0] vld,
                       input logic [63:0] dat, input logic [5:0] e, input logic [7:0] evld);
        vec_t t;
        t = {f, hit, vld, dat, e, evld};
        vq.push_back(t);
    endtask

    task automatic replay_lookup(input logic [11:0] idx, input logic [43:0] tag, input logic [63:0] d);
        @(negedge clk); set_def(); bus.rd_ack_i = 1'b1;
        #1;
        chk("rp_rd_req", bus.rd_req_o, 1);
        chk("rp_no_gnt", bus.gnt_o, 0);
        chk("rp_addr", {bus.rd_idx_o, bus.rd_off_o}, idx);
        chk("rp_busy", bus.busy_o, 1);
        @(negedge clk); set_def(); bus.tag_valid_i = 1'b1; bus.rd_data_i = d;
        bus.rd_hit_oh_i = 8'(1 << $urandom_range(0, 7));
        #1;
        chk("rp_rvalid", bus.rvalid_o, 1);
        chk("rp_rdata", bus.rdata_o, d);
        chk("rp_tag", bus.rd_tag_o, tag);
    endtask

    task automatic rnd_txn(input int kind);
        logic [11:0] idx;
        logic [43:0] tag;
        logic [1:0]  sz;
        logic [63:0] d, r;
        logic [7:0]  v;
        logic        en, killack;
        int          w;
        idx = 12'($urandom); tag = {12'($urandom), 32'($urandom)}; sz = 2'($urandom);
        d = {$urandom, $urandom}; r = {$urandom, $urandom}; v = 8'($urandom);
        en = (kind == K_HIT || kind == K_COLL) ? 1'b1 : 1'($urandom);
        w = $urandom_range(0, 2);
        for (int i = 0; i <= w; i++) begin
            @(negedge clk); set_def();
            bus.req_i = 1'b1; bus.addr_index_i = idx; bus.size_i = sz; bus.rd_ack_i = (i == w);
            #1;
            chk("r_idle_busy", bus.busy_o, 0);
            chk("r_rd_req", bus.rd_req_o, 1);
            chk("r_gnt", bus.gnt_o, (i == w));
            chk("r_rd_addr", {bus.rd_idx_o, bus.rd_off_o}, idx);
        end
        w = $urandom_range(0, 1);
        for (int i = 0; i < w; i++) begin
            @(negedge clk); set_def(); bus.rd_data_i = d;
            #1;
            chk("r_tagwait_rv", bus.rvalid_o, 0);
            chk("r_tagwait_busy", bus.busy_o, 1);
        end
        @(negedge clk); set_def();
        bus.tag_valid_i = 1'b1; bus.addr_tag_i = tag; bus.rd_data_i = d; bus.rd_vld_bits_i = v;
        bus.cache_en_i = en; bus.wr_cl_vld_i = (kind == K_COLL);
        bus.rd_hit_oh_i = (kind == K_HIT || kind == K_COLL || !en) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        #1;
        chk("r_rd_tag", bus.rd_tag_o, tag);
        chk("r_lookup_rv", bus.rvalid_o, (kind == K_HIT));
        if (kind == K_HIT) chk("r_hit_data", bus.rdata_o, d);
        if (kind == K_COLL) begin
            replay_lookup(idx, tag, d);
        end else if (kind != K_HIT) begin
            killack = (kind == K_KILL) && ($urandom_range(0, 1) == 1);
            w = $urandom_range(0, 1);
            for (int i = 0; i <= w; i++) begin
                @(negedge clk); set_def(); bus.cache_en_i = en;
                if (i == w && kind == K_RPLY) bus.miss_replay_i = 1'b1;
                if (i == w && kind != K_RPLY) begin bus.miss_ack_i = 1'b1; bus.kill_i = killack; end
                #1;
                chk("r_miss_req", bus.miss_req_o, 1);
                chk("r_miss_nc", bus.miss_nc_o, !en);
                chk("r_miss_paddr", bus.miss_paddr_o, {tag, idx});
                chk("r_miss_vld", bus.miss_vld_bits_o, v);
                chk("r_miss_size", bus.miss_size_o, {1'b0, sz});
                chk("r_miss_id", bus.miss_id_o, 1);
            end
            if (kind == K_RPLY) begin
                replay_lookup(idx, tag, r);
            end else begin
                w = (kind == K_KILL) ? $urandom_range(1, 3) : $urandom_range(0, 2);
                for (int j = 0; j < w; j++) begin
                    @(negedge clk); set_def();
                    bus.kill_i = (kind == K_KILL) && !killack && (j == 0);
                    #1;
                    chk("r_wait_rv", bus.rvalid_o, 0);
                    chk("r_wait_mreq", bus.miss_req_o, 0);
                    chk("r_wait_busy", bus.busy_o, 1);
                end
                @(negedge clk); set_def(); bus.miss_rtrn_vld_i = 1'b1; bus.miss_rtrn_data_i = r;
                #1;
                chk("r_rtrn_rv", bus.rvalid_o, (kind != K_KILL));
                if (kind != K_KILL) chk("r_rtrn_data", bus.rdata_o, r);
            end
        end
        @(negedge clk); set_def();
        #1;
        chk("r_end_busy", bus.busy_o, 0);
        chk("r_end_rv", bus.rvalid_o, 0);
    endtask

    initial begin
        vec_t v;
        int   k, exp_rv, exp_gnt, rv0, gnt0;
        rst_n = 1'b0;
        set_def();
        bus.addr_index_i = 12'h0; bus.addr_tag_i = 44'h0; bus.size_i = 2'b00;
        bus.rd_data_i = 64'h0; bus.miss_rtrn_data_i = 64'h0; bus.rd_vld_bits_i = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_rvalid", bus.rvalid_o, 0);
        chk("rst_miss_req", bus.miss_req_o, 0);
        chk("rst_paddr", bus.miss_paddr_o, 0);
        chk("rst_size", bus.miss_size_o, 0);
        chk("rst_miss_id", bus.miss_id_o, 1);
        @(negedge clk); rst_n = 1'b1;

        // hit
        add(10'b1010001000, 8'h00, 8'h00, 64'h0,    6'b101000, 8'h00);
        add(10'b0001001000, 8'h04, 8'h00, 64'hDEAD, 6'b010010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000000, 8'h00);
        // miss
        add(10'b1010001000, 8'h00, 8'h00, 64'h0,    6'b101000, 8'h00);
        add(10'b0001001000, 8'h00, 8'h0F, 64'h0,    6'b000010, 8'h00);
        add(10'b0000001100, 8'h00, 8'h00, 64'h0,    6'b000110, 8'h0F);
        add(10'b0000001001, 8'h00, 8'h00, 64'h55,   6'b010010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000000, 8'h00);
        // cache disabled: hit becomes a non-cacheable miss
        add(10'b1010000000, 8'h00, 8'h00, 64'h0,    6'b101000, 8'h00);
        add(10'b0001000000, 8'h04, 8'hFF, 64'hDEAD, 6'b000010, 8'h00);
        add(10'b0000000100, 8'h00, 8'h00, 64'h0,    6'b000111, 8'hFF);
        add(10'b0000000001, 8'h00, 8'h00, 64'h77,   6'b010010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000000, 8'h00);
        // kill while waiting for the refill
        add(10'b1010001000, 8'h00, 8'h00, 64'h0,    6'b101000, 8'h00);
        add(10'b0001001000, 8'h00, 8'h01, 64'h0,    6'b000010, 8'h00);
        add(10'b0000001100, 8'h00, 8'h00, 64'h0,    6'b000110, 8'h01);
        add(10'b0000101000, 8'h00, 8'h00, 64'h0,    6'b000010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000010, 8'h00);
        add(10'b0000001001, 8'h00, 8'h00, 64'h99,   6'b000010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000000, 8'h00);
        // cache-line write collision
        add(10'b1010001000, 8'h00, 8'h00, 64'h0,    6'b101000, 8'h00);
        add(10'b0001011000, 8'h04, 8'h00, 64'hDEAD, 6'b000010, 8'h00);
        add(10'b0010001000, 8'h00, 8'h00, 64'h0,    6'b001010, 8'h00);
        add(10'b0001001000, 8'h04, 8'h00, 64'hBEEF, 6'b010010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000000, 8'h00);
        // miss unit replay
        add(10'b1010001000, 8'h00, 8'h00, 64'h0,    6'b101000, 8'h00);
        add(10'b0001001000, 8'h00, 8'h03, 64'h0,    6'b000010, 8'h00);
        add(10'b0000001010, 8'h00, 8'h00, 64'h0,    6'b000110, 8'h03);
        add(10'b0010001000, 8'h00, 8'h00, 64'h0,    6'b001010, 8'h00);
        add(10'b0001001000, 8'h02, 8'h00, 64'h1234, 6'b010010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000000, 8'h00);
        // stall, then a request without ack, then granted
        add(10'b1110001000, 8'h00, 8'h00, 64'h0,    6'b000000, 8'h00);
        add(10'b1000001000, 8'h00, 8'h00, 64'h0,    6'b001000, 8'h00);
        add(10'b1010001000, 8'h00, 8'h00, 64'h0,    6'b101000, 8'h00);
        add(10'b0001001000, 8'h01, 8'h00, 64'h42,   6'b010010, 8'h00);
        add(10'b0000001000, 8'h00, 8'h00, 64'h0,    6'b000000, 8'h00);

        bus.addr_index_i = 12'h123; bus.addr_tag_i = 44'hABC; bus.size_i = 2'b11;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(negedge clk);
            {bus.req_i, bus.stall_i, bus.rd_ack_i, bus.tag_valid_i, bus.kill_i, bus.wr_cl_vld_i,
             bus.cache_en_i, bus.miss_ack_i, bus.miss_replay_i, bus.miss_rtrn_vld_i} = v.f;
            bus.rd_hit_oh_i = v.hit; bus.rd_vld_bits_i = v.vld;
            bus.rd_data_i = v.dat; bus.miss_rtrn_data_i = v.dat;
            #1;
            chk($sformatf("v%0d_gnt", i), bus.gnt_o, v.e[5]);
            chk($sformatf("v%0d_rvalid", i), bus.rvalid_o, v.e[4]);
            chk($sformatf("v%0d_rd_req", i), bus.rd_req_o, v.e[3]);
            chk($sformatf("v%0d_miss_req", i), bus.miss_req_o, v.e[2]);
            chk($sformatf("v%0d_busy", i), bus.busy_o, v.e[1]);
            chk($sformatf("v%0d_nc", i), bus.miss_nc_o, v.e[0]);
            if (v.e[4]) chk($sformatf("v%0d_rdata", i), bus.rdata_o, v.dat);
            if (v.e[3]) chk($sformatf("v%0d_rd_addr", i), {bus.rd_idx_o, bus.rd_off_o}, 12'h123);
            if (v.e[2]) begin
                chk($sformatf("v%0d_paddr", i), bus.miss_paddr_o, {44'hABC, 12'h123});
                chk($sformatf("v%0d_vld", i), bus.miss_vld_bits_o, v.evld);
                chk($sformatf("v%0d_size", i), bus.miss_size_o, 3'b011);
                chk($sformatf("v%0d_id", i), bus.miss_id_o, 1);
            end
        end

        exp_rv = 0; exp_gnt = 0;
        rv0 = rv_cnt; gnt0 = gnt_cnt;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 4);
            exp_gnt++;
            if (k != K_KILL) exp_rv++;
            rnd_txn(k);
        end
        chk("rnd_rvalid_count", 64'(rv_cnt - rv0), 64'(exp_rv));
        chk("rnd_gnt_count", 64'(gnt_cnt - gnt0), 64'(exp_gnt));

        // asynchronous reset in the middle of a lookup
        @(negedge clk); set_def(); bus.req_i = 1'b1; bus.rd_ack_i = 1'b1;
        @(negedge clk); set_def();
        #1;
        chk("arst_pre_busy", bus.busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_size", bus.miss_size_o, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
